// File: rtl/rr_arbiter8_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, requester count / index width, the
// post-reset "last winner" value and a small one-hot decode helper.
package rr_arbiter8_pkg;

    localparam int NREQ  = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Starting from 7 makes the first search after reset begin at index 0.
    localparam logic [IDX_W-1:0] LASTIDX_RST = 3'd7;

    function automatic logic [NREQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
        return NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Round-robin winner search: first set request at or after i_last_idx+1 (mod 8).
// Latency: purely combinational, zero cycles.
// Backpressure: none; o_any is simply the OR of all requests.
//
// Ports:
//   i_req      [7:0]  request vector, bit i = requester i
//   i_last_idx [2:0]  index of the previous winner
//   o_winner   [2:0]  selected index (valid only when o_any = 1)
//   o_any             at least one request is set
module rr_pick8
    import rr_arbiter8_pkg::*;
(
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_last_idx,
    output logic [IDX_W-1:0] o_winner,
    output logic             o_any
);

    logic [IDX_W-1:0]  w_offset;
    logic [2*NREQ-1:0] w_req2;
    logic [NREQ-1:0]   w_rot;
    logic [IDX_W-1:0]  w_pe_idx;

    // Search begins one past the previous winner; 3-bit add wraps 7 -> 0.
    assign w_offset = i_last_idx + IDX_W'(1);

    // Rotate right by w_offset: w_rot[j] = i_req[(j + offset) mod 8].
    // Taking a slice of the doubled vector avoids a variable-width shift.
    assign w_req2 = {i_req, i_req};
    assign w_rot  = w_req2[w_offset +: NREQ];

    // Fixed priority, lowest bit wins. Scanning downward lets the lowest
    // set bit be the last assignment.
    always_comb begin
        w_pe_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_pe_idx = IDX_W'(i);
            end
        end
    end

    // Undo the rotation; the add wraps modulo 8 naturally.
    assign o_winner = w_pe_idx + w_offset;
    assign o_any    = |i_req;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter sharing one resource among 8 requesters, with hold timeout.
// Latency: request sampled in IDLE -> registered grant on the next cycle; at
//          least one idle cycle separates consecutive grants.
// Backpressure: no queuing; requests seen during a grant are ignored until the
//          next IDLE cycle. i_en only gates new grants, never revokes one.
//
// Ports:
//   i_clk             rising-edge clock
//   i_reset           synchronous active-high reset (wins over everything)
//   i_en              arbitration enable, consulted only in IDLE
//   i_req      [7:0]  request vector
//   i_done            owner releases the resource (ignored in IDLE)
//   o_grant    [7:0]  registered one-hot grant, zero when idle
//   o_grant_idx[2:0]  registered owner index, holds last value when idle
//   o_busy            a grant is active
//   o_timeout         one-cycle pulse when the hold limit alone revoked a grant
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
)
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic [NREQ-1:0]  i_req,
    input  logic             i_done,
    output logic [NREQ-1:0]  o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_busy,
    output logic             o_timeout
);

    localparam bit               HOLD_EN  = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           r_state;
    logic [NREQ-1:0]  r_grant;
    // The owner index doubles as the round-robin pointer: it is only ever
    // written with a new winner and holds through IDLE, which is exactly
    // the "last winner" the search needs.
    logic [IDX_W-1:0] r_grant_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    state_t           w_state_nxt;
    logic [NREQ-1:0]  w_grant_nxt;
    logic [IDX_W-1:0] w_grant_idx_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_timeout_nxt;

    logic [IDX_W-1:0] w_winner;
    logic             w_any;
    logic             w_own_req;
    logic             w_hold_hit;
    logic             w_release;

    rr_pick8 u_pick (
        .i_req      (i_req),
        .i_last_idx (r_grant_idx),
        .o_winner   (w_winner),
        .o_any      (w_any)
    );

    assign w_own_req  = i_req[r_grant_idx];
    assign w_hold_hit = HOLD_EN && (r_cnt == HOLD_LIM);
    assign w_release  = i_done || !w_own_req || w_hold_hit;

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_grant_idx_nxt = r_grant_idx;
        w_cnt_nxt       = r_cnt;
        w_timeout_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_en && w_any) begin
                    w_state_nxt     = GRANT;
                    w_grant_nxt     = idx2onehot(w_winner);
                    w_grant_idx_nxt = w_winner;
                    w_cnt_nxt       = CNT_W'(1);
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_state_nxt   = IDLE;
                    w_grant_nxt   = '0;
                    w_cnt_nxt     = '0;
                    // Flag a timeout only when the owner would otherwise have
                    // kept the resource; a voluntary release in the same cycle
                    // is not a revocation.
                    w_timeout_nxt = w_hold_hit && !i_done && w_own_req;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_grant_idx <= LASTIDX_RST;
            r_cnt       <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign o_grant     = r_grant;
    assign o_grant_idx = r_grant_idx;
    assign o_busy      = (r_state == GRANT);
    assign o_timeout   = r_timeout;

    a_grant_onehot0: assert property (@(posedge i_clk) disable iff (i_reset)
        $onehot0(r_grant));
    a_grant_busy: assert property (@(posedge i_clk) disable iff (i_reset)
        ((r_grant != '0) == (r_state == GRANT)));
    a_timeout_idle: assert property (@(posedge i_clk) disable iff (i_reset)
        !(r_timeout && (r_state == GRANT)));

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: default-hold instance for the vector
// table, plus a MAX_HOLD=4 instance sharing the same inputs for timeout cases.
// Outputs are sampled 1 time unit after each rising edge.
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       done;

    logic [7:0] g0, g4;
    logic [2:0] gi0, gi4;
    logic       b0, b4;
    logic       t0, t4;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    rr_arbiter8 dut0 (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_req(req), .i_done(done),
        .o_grant(g0), .o_grant_idx(gi0), .o_busy(b0), .o_timeout(t0)
    );

    rr_arbiter8 #(.MAX_HOLD(4), .CNT_W(8)) dut4 (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_req(req), .i_done(done),
        .o_grant(g4), .o_grant_idx(gi4), .o_busy(b4), .o_timeout(t4)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] req;
        logic       done;
        logic [7:0] exp_grant;
        logic [2:0] exp_idx;
        logic       exp_busy;
        logic       exp_to;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic r, input logic e, input logic [7:0] rq, input logic d,
                       input logic [7:0] eg, input logic [2:0] ei, input logic eb,
                       input logic et);
        vec_t v;
        v.rst = r; v.en = e; v.req = rq; v.done = d;
        v.exp_grant = eg; v.exp_idx = ei; v.exp_busy = eb; v.exp_to = et;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tot++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = 8'h00; done = 1'b0;

        // Reset state, first grant favours requester 0.
        add(1, 0, 8'h00, 0, 8'h00, 3'd7, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00, 3'd7, 0, 0);
        add(0, 1, 8'h01, 0, 8'h01, 3'd0, 1, 0);
        add(0, 1, 8'h01, 1, 8'h00, 3'd0, 0, 0);
        // All requesting, Done each grant: 0..7,0 with one-cycle gaps.
        add(1, 0, 8'h00, 0, 8'h00, 3'd7, 0, 0);
        for (int k = 0; k < 9; k++) begin
            add(0, 1, 8'hFF, 0, 8'(1) << (k % 8), 3'(k % 8), 1, 0);
            add(0, 1, 8'hFF, 1, 8'h00,            3'(k % 8), 0, 0);
        end
        // Wrap from LastIdx=5 with Req=0010_0101: 0 then 2.
        add(0, 1, 8'h20, 0, 8'h20, 3'd5, 1, 0);
        add(0, 1, 8'h20, 1, 8'h00, 3'd5, 0, 0);
        add(0, 1, 8'h25, 0, 8'h01, 3'd0, 1, 0);
        add(0, 1, 8'h25, 1, 8'h00, 3'd0, 0, 0);
        add(0, 1, 8'h25, 0, 8'h04, 3'd2, 1, 0);
        // Owner drops its request -> release, no timeout.
        add(0, 1, 8'h21, 0, 8'h00, 3'd2, 0, 0);
        add(0, 1, 8'h21, 0, 8'h20, 3'd5, 1, 0);
        add(0, 1, 8'h21, 1, 8'h00, 3'd5, 0, 0);
        // En gating: blocks new grants, does not revoke an active one.
        add(0, 0, 8'h10, 0, 8'h00, 3'd5, 0, 0);
        add(0, 0, 8'h10, 0, 8'h00, 3'd5, 0, 0);
        add(0, 1, 8'h10, 0, 8'h10, 3'd4, 1, 0);
        add(0, 0, 8'h10, 0, 8'h10, 3'd4, 1, 0);
        add(0, 0, 8'h10, 0, 8'h10, 3'd4, 1, 0);
        add(0, 0, 8'h10, 1, 8'h00, 3'd4, 0, 0);
        add(0, 0, 8'h00, 1, 8'h00, 3'd4, 0, 0);
        add(0, 1, 8'h00, 0, 8'h00, 3'd4, 0, 0);
        // Reset mid-grant, then first winner is 0, next is 6.
        add(0, 1, 8'h40, 0, 8'h40, 3'd6, 1, 0);
        add(0, 1, 8'h40, 0, 8'h40, 3'd6, 1, 0);
        add(1, 1, 8'h41, 0, 8'h00, 3'd7, 0, 0);
        add(0, 1, 8'h41, 0, 8'h01, 3'd0, 1, 0);
        add(0, 1, 8'h41, 1, 8'h00, 3'd0, 0, 0);
        add(0, 1, 8'h41, 0, 8'h40, 3'd6, 1, 0);

        foreach (vt[i]) begin
            rst = vt[i].rst; en = vt[i].en; req = vt[i].req; done = vt[i].done;
            step();
            chk($sformatf("v%0d grant", i), g0,          vt[i].exp_grant);
            chk($sformatf("v%0d idx", i),   8'(gi0),     8'(vt[i].exp_idx));
            chk($sformatf("v%0d busy", i),  8'(b0),      8'(vt[i].exp_busy));
            chk($sformatf("v%0d tmo", i),   8'(t0),      8'(vt[i].exp_to));
        end

        // Hold timeout: Req=8'h08 held, Done=0. MAX_HOLD=4 instance grants
        // 4 cycles then one gap with Timeout; default instance holds 16.
        rst = 1'b1; en = 1'b0; req = 8'h00; done = 1'b0;
        step();
        rst = 1'b0; en = 1'b1; req = 8'h08;
        for (int s = 1; s <= 18; s++) begin
            step();
            chk($sformatf("h4 s%0d grant", s), g4,    (s % 5 != 0) ? 8'h08 : 8'h00);
            chk($sformatf("h4 s%0d tmo", s),   8'(t4), (s % 5 == 0) ? 8'd1 : 8'd0);
            chk($sformatf("h16 s%0d grant", s), g0,    (s == 17) ? 8'h00 : 8'h08);
            chk($sformatf("h16 s%0d tmo", s),   8'(t0), (s == 17) ? 8'd1 : 8'd0);
        end
        chk("h4 idx", 8'(gi4), 8'd3);

        // Done coinciding with the hold limit: release without Timeout.
        rst = 1'b1; req = 8'h00;
        step();
        rst = 1'b0; en = 1'b1; req = 8'h08; done = 1'b0;
        for (int s = 1; s <= 4; s++) begin
            step();
            chk($sformatf("co s%0d grant", s), g4, 8'h08);
        end
        done = 1'b1;
        step();
        chk("co grant", g4,     8'h00);
        chk("co tmo",   8'(t4), 8'd0);
        chk("co busy",  8'(b4), 8'd0);
        done = 1'b0; req = 8'h00;
        step();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
